limn2600_fetch_ctrl: RTL and testbench
======================================

Name: limn2600_fetch_ctrl

Overview:
- Instruction-fetch controller. Sits between the CPU fetch stage and the instruction cache data array, with the system memory bus behind it.
- Accepts fetch requests from the CPU and keeps the tag/valid store for a direct-mapped cache.
- On a hit, returns data from the cache data array. On a miss, runs a bus read, refills the data array and returns the fetched word.

Parameters:
- NUM_ENTRIES, 1024, number of cache lines (one 32-bit word each); must be a power of two.
- INDEX_BITS, $clog2(NUM_ENTRIES), line index width. Tag width is 30-INDEX_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cpu_req_valid  in  1  fetch request
- cpu_req_addr  in  32  fetch address; bits [1:0] ignored
- cpu_req_ready  out  1  controller accepts a request this cycle
- cpu_resp_valid  out  1  one-cycle response pulse
- cpu_resp_data  out  32  fetched instruction word
- flush  in  1  invalidate all lines
- cache_raddr  out  32  data-array read address; registered read, data valid next cycle
- cache_rdata  in  32  data-array read data
- cache_we  out  1  data-array write strobe
- cache_waddr  out  32  data-array write address
- cache_wdata  out  32  data-array write data
- bus_req  out  1  bus read request, held until ack
- bus_addr  out  32  word-aligned bus read address
- bus_ack  in  1  bus data valid
- bus_data  in  32  bus read data

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all valid bits 0, flush_pending 0. Reset mid-operation aborts any miss: bus_req drops at that edge and no fill is written. A bus_ack arriving after reset is ignored.
- index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2]. All addresses driven out have [1:0]=2'b00.
- cpu_req_ready = (state==IDLE) && !flush_pending. A request is accepted on valid&&ready. The address is latched, and cache_raddr is driven combinationally from cpu_req_addr while in IDLE.
- FSM states:
  - IDLE: on accept -> LOOKUP. If flush_pending, clear all valid bits in one cycle and clear flush_pending; no accept that cycle.
  - LOOKUP: cache_rdata is valid. On hit (valid[index] && tag match): resp_data <= cache_rdata, resp_valid <= 1, -> IDLE. On miss: -> BUS.
  - BUS: bus_req=1 with bus_addr stable. Zero-wait ack is allowed (ack in the first BUS cycle). On bus_ack: cache_we pulses for one cycle with waddr=latched addr and wdata=bus_data; valid[index] <= 1 and tag stored; resp_data <= bus_data, resp_valid <= 1; -> IDLE.
- Latency: hit response 2 cycles after accept. Miss response 2 + N cycles, where N = cycles spent in BUS.
- cpu_resp_valid is a single-cycle pulse with no backpressure. Back-to-back hits can be accepted every 2 cycles.
- flush is sampled every cycle and sets flush_pending. An in-flight miss completes and is returned normally, then the flush is applied in IDLE. A flush coinciding with a fill edge still ends with that line invalid.
- Simultaneous flush and cpu_req_valid in IDLE: flush wins; the request waits with ready low for one cycle.

Optional Feature:
- Macro LIMN2600_FETCH_STATS_EN.
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0]. Each increments on the LOOKUP hit/miss decision, wraps at 2^32, and is cleared by rst only, not by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package limn2600_pkg holds:
  - FSM state enum (IDLE, LOOKUP, BUS)
  - WORD_W=32
  - helper functions for addr_index/addr_tag
- Natural sub-module: limn2600_tag_store, holding the valid+tag RAM with single-cycle clear-all, a registered read port and one write port.

Test Plan:
- Reset then fetch 0x00001000 with bus_ack after 3 cycles and bus_data=0xDEADBEEF -> bus_req high 3 cycles, cache_we one pulse at 0x1000, resp 0xDEADBEEF 5 cycles after accept.
- Refetch 0x00001002 -> hit, no bus_req, resp = cache_rdata 2 cycles after accept.
- Fetch 0x00001000 then 0x00002000 (same index, NUM_ENTRIES=1024) -> second is a miss, its refill replaces the tag, and a subsequent 0x00001000 misses.
- Assert flush during a BUS wait -> current response delivered, ready low one extra IDLE cycle, next fetch of the same line misses.
- Assert rst while in BUS, then drive bus_ack 2 cycles later -> no cache_we, no resp_valid, ready=1 after reset deasserts.
- With LIMN2600_FETCH_STATS_EN defined, do 3 hits and 2 misses -> stat_hits=3, stat_misses=2; after flush the counts are unchanged.

Source files
------------

// File: rtl/limn2600_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : limn2600_pkg
// Purpose  : Shared types and helpers for the limn2600 instruction-fetch
//            controller: FSM state encoding, word width and address
//            index/tag extraction for a direct-mapped, one-word-per-line cache.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package limn2600_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_BUS    = 2'd2
  } fetch_state_e;

  // Line index: word address bits directly above the byte offset.
  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned index_bits);
    logic [31:0] mask;
    mask = (32'd1 << index_bits) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

  // Tag: every address bit above the index field.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned index_bits);
    return addr >> (index_bits + 32'd2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/limn2600_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : limn2600_fetch_ctrl_if
// Purpose  : Bundles the CPU fetch handshake, the cache data-array port and
//            the system bus read port of the fetch controller.
// Modports : master - the fetch controller
//            slave  - the environment (CPU, data array, bus)
// Signals  : cpu_req_valid/addr/ready, cpu_resp_valid/data, flush,
//            cache_raddr/rdata/we/waddr/wdata, bus_req/addr/ack/data
// Revision : 1.0 - initial release
// ============================================================================
interface limn2600_fetch_ctrl_if;
  import limn2600_pkg::*;

  logic              cpu_req_valid;
  logic [WORD_W-1:0] cpu_req_addr;
  logic              cpu_req_ready;
  logic              cpu_resp_valid;
  logic [WORD_W-1:0] cpu_resp_data;
  logic              flush;

  logic [WORD_W-1:0] cache_raddr;
  logic [WORD_W-1:0] cache_rdata;
  logic              cache_we;
  logic [WORD_W-1:0] cache_waddr;
  logic [WORD_W-1:0] cache_wdata;

  logic              bus_req;
  logic [WORD_W-1:0] bus_addr;
  logic              bus_ack;
  logic [WORD_W-1:0] bus_data;

  modport master (
    input  cpu_req_valid, cpu_req_addr, flush, cache_rdata, bus_ack, bus_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
           cache_raddr, cache_we, cache_waddr, cache_wdata, bus_req, bus_addr
  );

  modport slave (
    output cpu_req_valid, cpu_req_addr, flush, cache_rdata, bus_ack, bus_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
           cache_raddr, cache_we, cache_waddr, cache_wdata, bus_req, bus_addr
  );

endinterface
`default_nettype wire

// File: rtl/limn2600_fetch_ctrl_tag_store.sv
`default_nettype none
// ============================================================================
// Module   : limn2600_tag_store
// Purpose  : Valid+tag store of the direct-mapped instruction cache.
//            Valid bits live in flops so the whole store can be invalidated
//            in a single cycle; tags live in a plain RAM array.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clear_all     - invalidate every line this cycle
//            rd_index      - read index, result registered (next cycle)
//            rd_valid/tag  - registered read result
//            wr_en/index/tag - write port, sets the line valid
// Revision : 1.0 - initial release
// ============================================================================
module limn2600_tag_store #(
  parameter int NUM_ENTRIES = 1024,
  parameter int INDEX_BITS  = $clog2(NUM_ENTRIES),
  parameter int TAG_W       = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_all,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag
);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_mem [NUM_ENTRIES];
  logic                   rd_valid_q, rd_valid_d;
  logic [TAG_W-1:0]       rd_tag_q, rd_tag_d;

  always_comb begin
    valid_d = valid_q;
    if (clear_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end
    rd_valid_d = valid_q[rd_index];
    rd_tag_d   = tag_mem[rd_index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Tag contents need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index] <= wr_tag;
    end
    rd_tag_q <= rd_tag_d;
  end

  assign rd_valid = rd_valid_q;
  assign rd_tag   = rd_tag_q;

endmodule
`default_nettype wire

// File: rtl/limn2600_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : limn2600_fetch_ctrl
// Purpose  : Instruction-fetch controller in front of a direct-mapped,
//            one-word-per-line instruction cache. Hits are served from the
//            cache data array; misses run a bus read, refill the line and
//            return the fetched word.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            fif        - CPU / data-array / bus signals (master modport)
//            stat_hits, stat_misses - lookup counters (optional)
// Options  : LIMN2600_FETCH_STATS_EN adds the hit/miss counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module limn2600_fetch_ctrl
  import limn2600_pkg::*;
#(
  parameter int NUM_ENTRIES = 1024,
  parameter int INDEX_BITS  = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  limn2600_fetch_ctrl_if.master fif
`ifdef LIMN2600_FETCH_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  localparam int TAG_W = 30 - INDEX_BITS;

  fetch_state_e      state_q, state_d;
  logic [29:0]       addr_q, addr_d;          // latched word address
  logic              resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0] resp_data_q, resp_data_d;
  logic              flush_pending_q, flush_pending_d;

  logic                  ts_clear;
  logic                  ts_we;
  logic [INDEX_BITS-1:0] ts_rd_index;
  logic                  ts_rd_valid;
  logic [TAG_W-1:0]      ts_rd_tag;
  logic [INDEX_BITS-1:0] ts_wr_index;
  logic [TAG_W-1:0]      ts_wr_tag;
  logic                  hit;
  logic                  flush_now;

  // The tag read always follows the incoming request so its result lines up
  // with the data-array read in LOOKUP.
  assign ts_rd_index = INDEX_BITS'(addr_index(fif.cpu_req_addr, INDEX_BITS));
  assign ts_wr_index = INDEX_BITS'(addr_index({addr_q, 2'b00}, INDEX_BITS));
  assign ts_wr_tag   = TAG_W'(addr_tag({addr_q, 2'b00}, INDEX_BITS));
  assign hit         = ts_rd_valid && (ts_rd_tag == ts_wr_tag);

  // A flush seen in IDLE is applied at once, so it beats a simultaneous
  // request and costs exactly one stalled cycle.
  assign flush_now = flush_pending_q || fif.flush;

  limn2600_tag_store #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .INDEX_BITS  (INDEX_BITS),
    .TAG_W       (TAG_W)
  ) u_tag_store (
    .clk       (clk),
    .rst       (rst),
    .clear_all (ts_clear),
    .rd_index  (ts_rd_index),
    .rd_valid  (ts_rd_valid),
    .rd_tag    (ts_rd_tag),
    .wr_en     (ts_we),
    .wr_index  (ts_wr_index),
    .wr_tag    (ts_wr_tag)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    resp_valid_d    = 1'b0;
    resp_data_d     = resp_data_q;
    flush_pending_d = flush_pending_q || fif.flush;
    ts_clear        = 1'b0;
    ts_we           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_now) begin
          ts_clear        = 1'b1;
          flush_pending_d = 1'b0;
        end else if (fif.cpu_req_valid) begin
          addr_d  = fif.cpu_req_addr[31:2];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          resp_data_d  = fif.cache_rdata;
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (fif.bus_ack) begin
          ts_we        = 1'b1;
          resp_data_d  = fif.bus_data;
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign fif.cpu_req_ready  = (state_q == ST_IDLE) && !flush_now && !rst;
  assign fif.cpu_resp_valid = resp_valid_q;
  assign fif.cpu_resp_data  = resp_data_q;
  assign fif.cache_raddr    = (state_q == ST_IDLE) ? {fif.cpu_req_addr[31:2], 2'b00}
                                                   : {addr_q, 2'b00};
  // The fill is written in the ack cycle itself so a request accepted on the
  // very next cycle already reads the new word from the data array.
  assign fif.cache_we       = (state_q == ST_BUS) && fif.bus_ack && !rst;
  assign fif.cache_waddr    = {addr_q, 2'b00};
  assign fif.cache_wdata    = fif.cache_we ? fif.bus_data : '0;
  assign fif.bus_req        = (state_q == ST_BUS);
  assign fif.bus_addr       = {addr_q, 2'b00};

`ifdef LIMN2600_FETCH_STATS_EN
  logic        lookup_hit, lookup_miss;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;

  assign lookup_hit  = (state_q == ST_LOOKUP) && hit;
  assign lookup_miss = (state_q == ST_LOOKUP) && !hit;

  always_comb begin
    stat_hits_d   = stat_hits_q + {31'd0, lookup_hit};
    stat_misses_d = stat_misses_q + {31'd0, lookup_miss};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_limn2600_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_limn2600_fetch_ctrl
// Purpose  : Self-checking bench for limn2600_fetch_ctrl: directed vector
//            table, hand-written flush/reset sequences and random fetches
//            against a line-level cache model. Optional counters are checked
//            when LIMN2600_FETCH_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_limn2600_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  limn2600_fetch_ctrl_if ifc();

`ifdef LIMN2600_FETCH_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  limn2600_fetch_ctrl #(.NUM_ENTRIES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .fif (ifc)
`ifdef LIMN2600_FETCH_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  // Data array: registered read, write at the clock edge.
  logic [31:0] cmem [1024];
  always @(posedge clk) begin
    if (ifc.cache_we) cmem[ifc.cache_waddr[11:2]] <= ifc.cache_wdata;
    ifc.cache_rdata <= cmem[ifc.cache_raddr[11:2]];
  end

  // Line-level model: each line remembers the full word address it holds.
  bit          m_valid [1024];
  logic [29:0] m_word  [1024];
  logic [31:0] m_data  [1024];
  int          m_hits, m_misses;

  int checks = 0;
  int errors = 0;

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_word[line_of(a)] == a[31:2]);
  endfunction

  function automatic void m_flush();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!ifc.cpu_req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!ifc.cpu_req_ready) chk("ready_timeout", 32'(ifc.cpu_req_ready), 32'd1);
  endtask

  // One fetch: nb = BUS cycles before ack (ack in the nb-th), fc = cycle after
  // accept on which flush is pulsed (0 = none).
  task automatic fetch(input logic [31:0] a, input int nb, input logic [31:0] bd,
                       input int fc, input bit exp_hit, input logic [31:0] exp_data);
    int cyc, nbus, nwe, lat;
    bit done, mh;
    mh = m_hit(a);
    wait_ready();
    ifc.cpu_req_valid = 1'b1;
    ifc.cpu_req_addr  = a;
    #1;
    chk("raddr", ifc.cache_raddr, {a[31:2], 2'b00});
    @(negedge clk);
    ifc.cpu_req_valid = 1'b0;
    ifc.cpu_req_addr  = $urandom;
    cyc = 1; nbus = 0; nwe = 0; done = 1'b0;
    lat = exp_hit ? 2 : nb + 2;
    while (!done && cyc <= 40) begin
      ifc.bus_ack = 1'b0;
      ifc.flush   = (cyc == fc);
      if (ifc.bus_req) begin
        nbus++;
        chk("bus_addr", ifc.bus_addr, {a[31:2], 2'b00});
        ifc.bus_data = (nbus == nb) ? bd : $urandom;
        ifc.bus_ack  = (nbus == nb);
      end
      #1;
      if (ifc.cache_we) begin
        nwe++;
        chk("cache_waddr", ifc.cache_waddr, {a[31:2], 2'b00});
        chk("cache_wdata", ifc.cache_wdata, bd);
      end
      if (ifc.cpu_resp_valid) begin
        done = 1'b1;
        chk("resp_latency", 32'(cyc), 32'(lat));
        chk("resp_data", ifc.cpu_resp_data, exp_data);
        chk("bus_cycles", 32'(nbus), exp_hit ? 32'd0 : 32'(nb));
        chk("fill_writes", 32'(nwe), exp_hit ? 32'd0 : 32'd1);
        chk("ready_at_resp", 32'(ifc.cpu_req_ready), (fc == 0) ? 32'd1 : 32'd0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    ifc.flush   = 1'b0;
    ifc.bus_ack = 1'b0;
    if (!done) chk("resp_timeout", 32'(done), 32'd1);
    if (mh) begin
      m_hits++;
    end else begin
      m_misses++;
      m_valid[line_of(a)] = 1'b1;
      m_word[line_of(a)]  = a[31:2];
      m_data[line_of(a)]  = bd;
    end
    if (fc > 0) begin
      m_flush();
      if (done) begin
        @(negedge clk);
        #1;
        chk("ready_after_flush", 32'(ifc.cpu_req_ready), 32'd1);
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          nb;
    logic [31:0] bd;
    int          fc;
    bit          hit;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, bd;
    int nb, fc, bad_we, bad_resp;
    bit mh;

    tbl[0]  = '{32'h0000_1000, 3, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF};
    tbl[1]  = '{32'h0000_1002, 1, 32'h0BAD_0BAD, 0, 1'b1, 32'hDEAD_BEEF};
    tbl[2]  = '{32'h0000_2000, 1, 32'h1234_5678, 0, 1'b0, 32'h1234_5678};
    tbl[3]  = '{32'h0000_1000, 2, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D};
    tbl[4]  = '{32'h0000_1000, 1, 32'h0BAD_0BAD, 0, 1'b1, 32'hCAFE_F00D};
    tbl[5]  = '{32'h0000_3004, 4, 32'h0A5A_5A5A, 3, 1'b0, 32'h0A5A_5A5A};
    tbl[6]  = '{32'h0000_3004, 1, 32'h1111_2222, 0, 1'b0, 32'h1111_2222};
    tbl[7]  = '{32'h0000_1000, 1, 32'h3333_4444, 2, 1'b0, 32'h3333_4444};
    tbl[8]  = '{32'h0000_1000, 2, 32'h5555_6666, 0, 1'b0, 32'h5555_6666};
    tbl[9]  = '{32'h0000_3004, 1, 32'h7777_8888, 0, 1'b0, 32'h7777_8888};
    tbl[10] = '{32'h0000_3004, 1, 32'h0BAD_0BAD, 0, 1'b1, 32'h7777_8888};
    tbl[11] = '{32'h0000_1003, 1, 32'h0BAD_0BAD, 1, 1'b1, 32'h5555_6666};
    tbl[12] = '{32'h0000_1000, 3, 32'h9999_AAAA, 0, 1'b0, 32'h9999_AAAA};

    m_flush();
    m_hits = 0; m_misses = 0;
    rst = 1'b1;
    ifc.cpu_req_valid = 1'b0;
    ifc.cpu_req_addr  = '0;
    ifc.flush         = 1'b0;
    ifc.bus_ack       = 1'b0;
    ifc.bus_data      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(ifc.cpu_resp_valid), 32'd0);
    chk("rst_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("rst_cache_we", 32'(ifc.cache_we), 32'd0);
    chk("rst_ready", 32'(ifc.cpu_req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ifc.cpu_req_ready), 32'd1);
    chk("post_rst_bus_addr", ifc.bus_addr, 32'd0);
    chk("post_rst_resp_data", ifc.cpu_resp_data, 32'd0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      fetch(tbl[i].addr, tbl[i].nb, tbl[i].bd, tbl[i].fc, tbl[i].hit, tbl[i].data);
    end

    // Flush and request in the same IDLE cycle: flush wins for one cycle
    wait_ready();
    ifc.cpu_req_addr  = 32'h0000_1000;
    ifc.cpu_req_valid = 1'b1;
    ifc.flush         = 1'b1;
    #1;
    chk("ready_flush_same_cycle", 32'(ifc.cpu_req_ready), 32'd0);
    @(negedge clk);
    ifc.flush = 1'b0;
    #1;
    chk("ready_after_same_cycle_flush", 32'(ifc.cpu_req_ready), 32'd1);
    ifc.cpu_req_valid = 1'b0;
    m_flush();
    fetch(32'h0000_1000, 2, 32'hABCD_0123, 0, 1'b0, 32'hABCD_0123);

    // Random fetches over a small address pool so lines are shared
    for (int k = 0; k < 150; k++) begin
      a  = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      nb = $urandom_range(1, 4);
      bd = $urandom;
      mh = m_hit(a);
      fc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, mh ? 1 : nb + 1) : 0;
      fetch(a, nb, bd, fc, mh, mh ? m_data[line_of(a)] : bd);
    end

`ifdef LIMN2600_FETCH_STATS_EN
    chk("stat_hits", stat_hits, 32'(m_hits));
    chk("stat_misses", stat_misses, 32'(m_misses));
    wait_ready();
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    repeat (2) @(negedge clk);
    m_flush();
    chk("stat_hits_after_flush", stat_hits, 32'(m_hits));
    chk("stat_misses_after_flush", stat_misses, 32'(m_misses));
`endif

    // Reset while waiting on the bus, then a late ack
    wait_ready();
    ifc.cpu_req_valid = 1'b1;
    ifc.cpu_req_addr  = 32'h0000_5008;
    @(negedge clk);
    ifc.cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("bus_req_before_rst", 32'(ifc.bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("bus_req_at_rst", 32'(ifc.bus_req), 32'd0);
    rst = 1'b0;
    bad_we = 0; bad_resp = 0;
    for (int k = 1; k <= 6; k++) begin
      ifc.bus_ack  = (k == 2);
      ifc.bus_data = 32'hBAD0_BAD0;
      #1;
      if (ifc.cache_we) bad_we++;
      if (ifc.cpu_resp_valid) bad_resp++;
      if (k == 1) chk("ready_after_rst", 32'(ifc.cpu_req_ready), 32'd1);
      @(negedge clk);
    end
    ifc.bus_ack = 1'b0;
    chk("late_ack_fill_writes", 32'(bad_we), 32'd0);
    chk("late_ack_responses", 32'(bad_resp), 32'd0);
    m_flush();
    m_hits = 0; m_misses = 0;
`ifdef LIMN2600_FETCH_STATS_EN
    chk("stat_hits_rst", stat_hits, 32'd0);
    chk("stat_misses_rst", stat_misses, 32'd0);
`endif
    fetch(32'h0000_5008, 2, 32'h600D_F00D, 0, 1'b0, 32'h600D_F00D);
    fetch(32'h0000_5008, 1, 32'h0BAD_0BAD, 0, 1'b1, 32'h600D_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
